// File: rtl/button_pulser_if.sv
// button_pulser_if: raw button in, debounced level and press/repeat strobe out.
interface button_pulser_if;
    logic btn_in;
    logic btn_level;
    logic pulse;
    modport master (output btn_in, input btn_level, pulse);
    modport slave (input btn_in, output btn_level, pulse);
endinterface

// File: rtl/button_pulser.sv
// button_pulser: synchronize and debounce a push button into a level and single-cycle press/repeat pulses.
module button_pulser #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic            clk,
    input  logic            reset,
    button_pulser_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    logic          sync1, sync_q, level, pulse_q, pulse_d;
    logic          accept, rise, fall;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rep_cnt, rep_d;
    state_t        state, state_d;

    // rise/fall mark the exact edge the debounced level flips, so pulse lands with it
    assign accept = (sync_q != level) && (db_cnt == DB_MAX);
    assign rise   = accept && sync_q;
    assign fall   = accept && !sync_q;

    assign bus.btn_level = level;
    assign bus.pulse     = pulse_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync_q  <= 1'b0;
            level   <= 1'b0;
            db_cnt  <= '0;
            state   <= IDLE;
            rep_cnt <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1   <= bus.btn_in;
            sync_q  <= sync1;
            level   <= accept ? sync_q : level;
            db_cnt  <= (sync_q == level || accept) ? '0 : db_cnt + DW'(1);
            state   <= state_d;
            rep_cnt <= rep_d;
            pulse_q <= pulse_d;
        end
    end

    // release is tested first so it wins over a coincident repeat
    always_comb begin
        state_d = state;
        rep_d   = rep_cnt;
        pulse_d = 1'b0;
        case (state)
            IDLE: if (rise) begin
                state_d = HELD;
                rep_d   = '0;
                pulse_d = 1'b1;
            end
            HELD: if (fall) begin
                state_d = IDLE;
                rep_d   = '0;
            end else if (REPEAT_EN != 0 && rep_cnt == DELAY_MAX) begin
                state_d = REPEAT;
                rep_d   = '0;
                pulse_d = 1'b1;
            end else begin
                rep_d = (rep_cnt == DELAY_MAX) ? rep_cnt : rep_cnt + RW'(1);
            end
            REPEAT: if (fall) begin
                state_d = IDLE;
                rep_d   = '0;
            end else if (rep_cnt == PERIOD_MAX) begin
                rep_d   = '0;
                pulse_d = 1'b1;
            end else begin
                rep_d = rep_cnt + RW'(1);
            end
            default: begin
                state_d = IDLE;
                rep_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_button_pulser.sv
// tb_button_pulser: directed checks of debounce, press pulse, auto-repeat and reset, with and without repeat.
module tb_button_pulser;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    button_pulser_if bif0 ();
    button_pulser_if bif1 ();
    assign bif0.btn_in = btn;
    assign bif1.btn_in = btn;

    button_pulser #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3))
        dut0 (.clk(clk), .reset(reset), .bus(bif0));
    button_pulser #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3))
        dut1 (.clk(clk), .reset(reset), .bus(bif1));

    // downstream enable-driven counters: 8-bit on the plain output, 2-bit on the repeating one
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (bif0.pulse) cnt0 <= cnt0 + 8'd1;
            if (bif1.pulse) cnt1 <= cnt1 + 2'd1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        reset = 1'b1;
        btn = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({bif0.btn_level, bif0.pulse, bif1.btn_level, bif1.pulse} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset k=%0d outputs got %b%b%b%b exp 0000", k,
                         bif0.btn_level, bif0.pulse, bif1.btn_level, bif1.pulse);
            end
        end
        reset = 1'b0;
    endtask

    // press at edge 0, repeats at 13,16,..,40; release lands on edge 43 where a repeat is also due
    task automatic test_press_repeat;
        logic el, ep0, ep1;
        btn = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (k == 37) btn = 1'b0;
            el  = (k >= 5 && k < 43);
            ep0 = (k == 5);
            ep1 = (k == 5) || (k >= 13 && k < 43 && (k - 13) % 3 == 0);
            vectors++;
            if (bif0.btn_level !== el) begin
                miscompares++;
                $display("FAIL press level0 k=%0d got %b exp %b", k, bif0.btn_level, el);
            end
            vectors++;
            if (bif0.pulse !== ep0) begin
                miscompares++;
                $display("FAIL press pulse0 k=%0d got %b exp %b", k, bif0.pulse, ep0);
            end
            vectors++;
            if (bif1.btn_level !== el) begin
                miscompares++;
                $display("FAIL repeat level1 k=%0d got %b exp %b", k, bif1.btn_level, el);
            end
            vectors++;
            if (bif1.pulse !== ep1) begin
                miscompares++;
                $display("FAIL repeat pulse1 k=%0d got %b exp %b", k, bif1.pulse, ep1);
            end
            if (k == 19) begin
                vectors++;
                if (cnt1 !== 2'd3) begin
                    miscompares++;
                    $display("FAIL repeat cnt1_before_wrap got %0d exp 3", cnt1);
                end
            end
            if (k == 20) begin
                vectors++;
                if (cnt1 !== 2'd0) begin
                    miscompares++;
                    $display("FAIL repeat cnt1_wrap got %0d exp 0", cnt1);
                end
            end
        end
        vectors++;
        if (cnt0 !== 8'd1) begin
            miscompares++;
            $display("FAIL press cnt0_total got %0d exp 1", cnt0);
        end
        vectors++;
        if (cnt1 !== 2'd3) begin
            miscompares++;
            $display("FAIL repeat cnt1_total got %0d exp 3", cnt1);
        end
    endtask

    task automatic test_bounce;
        logic [5:0] seq;
        logic el, ep;
        seq = 6'b101101;
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            btn = (k < 6) ? seq[5 - k] : 1'b1;
            tick();
            el = (k >= 10);
            ep = (k == 10);
            vectors++;
            if (bif0.btn_level !== el || bif1.btn_level !== el) begin
                miscompares++;
                $display("FAIL bounce level k=%0d got %b/%b exp %b", k, bif0.btn_level, bif1.btn_level, el);
            end
            vectors++;
            if (bif0.pulse !== ep || bif1.pulse !== ep) begin
                miscompares++;
                $display("FAIL bounce pulse k=%0d got %b/%b exp %b", k, bif0.pulse, bif1.pulse, ep);
            end
        end
    endtask

    task automatic test_glitch;
        reset_dut();
        for (int k = 0; k < 15; k++) begin
            btn = (k < 3);
            tick();
            vectors++;
            if ({bif0.btn_level, bif0.pulse, bif1.btn_level, bif1.pulse} !== 4'b0000) begin
                miscompares++;
                $display("FAIL glitch k=%0d outputs got %b%b%b%b exp 0000", k,
                         bif0.btn_level, bif0.pulse, bif1.btn_level, bif1.pulse);
            end
        end
    endtask

    task automatic test_release_repress;
        logic el, ep0, ep1;
        reset_dut();
        btn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k == 9) btn = 1'b0;
            if (k == 19) btn = 1'b1;
            el  = (k >= 5 && k < 15) || (k >= 25);
            ep0 = (k == 5) || (k == 25);
            ep1 = ep0 || (k == 13);
            vectors++;
            if (bif0.btn_level !== el) begin
                miscompares++;
                $display("FAIL repress level0 k=%0d got %b exp %b", k, bif0.btn_level, el);
            end
            vectors++;
            if (bif0.pulse !== ep0) begin
                miscompares++;
                $display("FAIL repress pulse0 k=%0d got %b exp %b", k, bif0.pulse, ep0);
            end
            vectors++;
            if (bif1.pulse !== ep1) begin
                miscompares++;
                $display("FAIL repress pulse1 k=%0d got %b exp %b", k, bif1.pulse, ep1);
            end
        end
        vectors++;
        if (cnt0 !== 8'd2) begin
            miscompares++;
            $display("FAIL repress cnt0_total got %0d exp 2", cnt0);
        end
    endtask

    // reset lands on edge 19, where dut1 would otherwise issue a repeat
    task automatic test_reset_repeat;
        logic el, ep;
        reset_dut();
        btn = 1'b1;
        for (int k = 0; k < 19; k++) tick();
        reset = 1'b1;
        tick();
        vectors++;
        if ({bif0.btn_level, bif0.pulse, bif1.btn_level, bif1.pulse} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset outputs got %b%b%b%b exp 0000",
                     bif0.btn_level, bif0.pulse, bif1.btn_level, bif1.pulse);
        end
        reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            el = (j >= 5);
            ep = (j == 5);
            vectors++;
            if (bif0.btn_level !== el || bif1.btn_level !== el) begin
                miscompares++;
                $display("FAIL midreset level j=%0d got %b/%b exp %b", j, bif0.btn_level, bif1.btn_level, el);
            end
            vectors++;
            if (bif0.pulse !== ep || bif1.pulse !== ep) begin
                miscompares++;
                $display("FAIL midreset pulse j=%0d got %b/%b exp %b", j, bif0.pulse, bif1.pulse, ep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_repeat();
        test_bounce();
        test_glitch();
        test_release_repress();
        test_reset_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/button_pulser.md
# button_pulser

Conditions a raw, asynchronous, bouncing push-button input into a clean debounced level and single-cycle pulses, with optional hold-to-repeat. It is the producer that drives the `enable` input of the lab counters: one press gives exactly one `pulse` cycle, so the counter advances by exactly one. It sits between the board button pin and any enable-driven counter in the same clock domain.

## Interface

- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz); minimum 2.
- `REPEAT_EN`, default 0: 1 enables auto-repeat while the button is held.
- `REPEAT_DELAY`, default 50_000_000: cycles from the first pulse to the first repeat pulse; minimum 2.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent repeat pulses; minimum 2.

- `clk` input 1: clock.
- `reset` input 1: reset; synchronous, active-high.
- `btn_in` input 1: raw button, active-high, asynchronous to `clk`, may bounce.
- `btn_level` output 1: debounced button level, registered.
- `pulse` output 1: one-cycle strobe per accepted press and per repeat; connects to a counter `enable`.

## Operation

- Synchronizer: two flip-flops, `sync1 <= btn_in` and `sync_q <= sync1`. Both reset to 0. No other logic samples `btn_in`.
- Debounce counter `db_cnt`:
  - Width is $clog2(DEBOUNCE_CYCLES).
  - If `sync_q == btn_level`, then `db_cnt <= 0`.
  - If `sync_q != btn_level` and `db_cnt == DEBOUNCE_CYCLES-1`, then `btn_level <= sync_q` and `db_cnt <= 0`.
  - Otherwise `db_cnt <= db_cnt + 1`.
  - Any disagreement shorter than DEBOUNCE_CYCLES (a glitch or bounce) leaves `btn_level` unchanged and restarts the count.
- FSM states:
  - IDLE: `btn_level` is 0. On the edge where `btn_level` goes 0→1, `pulse <= 1`, `rep_cnt <= 0`, and the FSM moves to HELD.
  - HELD: `btn_level` is 1 and no repeat has fired yet. `rep_cnt` increments each cycle. If REPEAT_EN=1 and `rep_cnt == REPEAT_DELAY-1`, then `pulse <= 1`, `rep_cnt <= 0`, and the FSM moves to REPEAT. If REPEAT_EN=0, the FSM stays in HELD and no further pulses occur.
  - REPEAT: `rep_cnt` increments. When `rep_cnt == REPEAT_PERIOD-1`, then `pulse <= 1` and `rep_cnt <= 0`.
  - From HELD or REPEAT: on the edge where `btn_level` goes 1→0, the FSM moves to IDLE, `rep_cnt <= 0`, and no pulse is issued. Release has priority over a coincident repeat.
- `pulse` is 0 on every edge not named above. It is never high for two consecutive cycles.
- `rep_cnt` width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). Counters never wrap; they are cleared explicitly.
- Release never produces a pulse.

## Timing

- Reset values: `sync1`, `sync_q`, `btn_level`, `pulse`, `db_cnt` and `rep_cnt` are all 0; the FSM is in IDLE.
- Press latency: `btn_in` rises before edge 0 and stays high. Then `sync_q` = 1 after edge 1, and `btn_level` and `pulse` both go 1 after edge DEBOUNCE_CYCLES+1. The latency is DEBOUNCE_CYCLES+2 cycles; `pulse` is coincident with the rising `btn_level`.
- Release latency is the same, DEBOUNCE_CYCLES+2 cycles from the fall of `btn_in` to the fall of `btn_level`.
- Repeat pulses: with the first pulse in cycle P, repeats occur in cycles P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, and so on, while `btn_level` stays 1.
- Reset mid-operation: all state clears on the next edge, and any pending pulse is dropped. If `btn_in` is still high after reset deasserts, the press is re-accepted after the full debounce latency and issues one new pulse.
- Reset has priority over all other behaviour.

## Test plan

Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.

1. Reset, then a clean press: after 3 cycles of `reset`, hold `btn_in`=1 from edge 0 for 20 cycles. Required: `btn_level` and `pulse` = 0 during reset; `btn_level`=1 and `pulse`=1 after edge 5 only; with REPEAT_EN=0, exactly 1 pulse in total; a counter fed by `pulse` reads 1.
2. Bounce rejection: `btn_in` toggles 1,0,1,1,0,1 on successive cycles, then stays 1. Required: no pulse during the bounce; exactly 1 pulse, 6 cycles after the final stable rise is captured.
3. Glitch: drive `btn_in`=1 for 3 cycles, then 0. Required: `btn_level` stays 0 and `pulse` is never asserted.
4. Auto-repeat (REPEAT_EN=1): hold `btn_in` for 30 cycles after acceptance. Required: pulses at P, P+8, P+11, P+14, … through the hold; release gives no pulse; a 2-bit counter wraps 3→0 on the fourth pulse.
5. Release and re-press: press, release after 10 cycles, press again. Required: exactly 2 pulses, and `btn_level` falls 6 cycles after `btn_in` falls.
6. Reset while held in REPEAT: assert `reset` for 1 cycle. Required: all outputs are 0 the next cycle; a new single pulse arrives 6 cycles after reset deasserts.
